// File: rtl/softmax_sub_ctrl.sv
// softmax_sub_ctrl: sequencer for the 4-lane max-subtract stage of the softmax path.
// Each input buffer location (4 x DW words) is read, handed to the external subtract
// datapath with the latched max value, and the registered results are written to the
// output RAM in one RD/EXE/WR pass. The write phase stalls on wr_ready.
// Optional feature: define SUB_SAT_CNT_EN to add the sat_cnt output, which counts lanes
// that return the datapath saturation code during a run.
module softmax_sub_ctrl #(
    parameter int unsigned DW        = 16,
    parameter int unsigned RD_AWIDTH = 4,
    parameter int unsigned WR_AWIDTH = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [RD_AWIDTH:0]     num_locs,
    input  logic [RD_AWIDTH-1:0]   rd_base,
    input  logic [WR_AWIDTH-1:0]   wr_base,
    input  logic [DW-1:0]          max_in,
    output logic                   busy,
    output logic                   done,
    output logic                   rd_en,
    output logic [RD_AWIDTH-1:0]   rd_addr,
    input  logic [4*DW-1:0]        rd_data,
    output logic [DW-1:0]          sub_a0,
    output logic [DW-1:0]          sub_a1,
    output logic [DW-1:0]          sub_a2,
    output logic [DW-1:0]          sub_a3,
    output logic [DW-1:0]          sub_b,
    input  logic [DW-1:0]          sub_res0,
    input  logic [DW-1:0]          sub_res1,
    input  logic [DW-1:0]          sub_res2,
    input  logic [DW-1:0]          sub_res3,
    output logic                   wr_en,
    output logic [WR_AWIDTH-1:0]   wr_addr,
    output logic [4*DW-1:0]        wr_data,
    input  logic                   wr_ready
`ifdef SUB_SAT_CNT_EN
    ,
    output logic [7:0]             sat_cnt
`endif
);

    typedef enum logic [2:0] {StIdle, StRd, StExe, StWr, StDone} state_e;

    localparam logic [RD_AWIDTH:0] IdxOne = 1;

    state_e                 state_q, state_d;
    logic [RD_AWIDTH:0]     idx_q;
    logic [RD_AWIDTH:0]     num_locs_q;
    logic [RD_AWIDTH-1:0]   rd_base_q;
    logic [WR_AWIDTH-1:0]   wr_base_q;
    logic [DW-1:0]          max_q;
    logic [4*DW-1:0]        wr_data_q;

    logic start_ok;
    logic last_loc;
    logic wr_accept;

    assign start_ok  = (state_q == StIdle) && start;
    assign last_loc  = (idx_q == (num_locs_q - IdxOne));
    assign wr_accept = (state_q == StWr) && wr_ready;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (num_locs == '0) ? StDone : StRd;
                end
            end
            StRd:  state_d = StExe;
            StExe: state_d = StWr;
            StWr: begin
                if (wr_ready) begin
                    state_d = last_loc ? StDone : StRd;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Run parameters are captured only on an accepted start so they stay fixed mid-run
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q      <= '0;
            num_locs_q <= '0;
            rd_base_q  <= '0;
            wr_base_q  <= '0;
            max_q      <= '0;
        end else if (start_ok) begin
            idx_q      <= '0;
            num_locs_q <= num_locs;
            rd_base_q  <= rd_base;
            wr_base_q  <= wr_base;
            max_q      <= max_in;
        end else if (wr_accept && !last_loc) begin
            idx_q <= idx_q + IdxOne;
        end
    end

    // Capture datapath results at the end of EXE; held through any WR stall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_data_q <= '0;
        end else if (state_q == StExe) begin
            wr_data_q <= {sub_res3, sub_res2, sub_res1, sub_res0};
        end
    end

    // Output decode from the current state
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        rd_en   = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        sub_a0  = '0;
        sub_a1  = '0;
        sub_a2  = '0;
        sub_a3  = '0;
        unique case (state_q)
            StIdle: ;
            StRd: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                rd_addr = rd_base_q + idx_q[RD_AWIDTH-1:0];
            end
            StExe: begin
                busy   = 1'b1;
                sub_a0 = rd_data[0*DW +: DW];
                sub_a1 = rd_data[1*DW +: DW];
                sub_a2 = rd_data[2*DW +: DW];
                sub_a3 = rd_data[3*DW +: DW];
            end
            StWr: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = wr_base_q + WR_AWIDTH'(idx_q);
            end
            StDone: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign sub_b   = max_q;
    assign wr_data = wr_data_q;

`ifdef SUB_SAT_CNT_EN
    // Saturation code: sign bit set, all other bits clear
    localparam logic [DW-1:0] SatCode = {1'b1, {(DW-1){1'b0}}};

    logic [7:0] sat_cnt_q;
    logic [2:0] sat_hits;
    logic [8:0] sat_sum;

    // Count lanes returning the saturation code in this EXE cycle
    always_comb begin
        sat_hits = 3'd0;
        if (sub_res0 == SatCode) sat_hits = sat_hits + 3'd1;
        if (sub_res1 == SatCode) sat_hits = sat_hits + 3'd1;
        if (sub_res2 == SatCode) sat_hits = sat_hits + 3'd1;
        if (sub_res3 == SatCode) sat_hits = sat_hits + 3'd1;
        sat_sum = {1'b0, sat_cnt_q} + {6'd0, sat_hits};
    end

    // Saturating counter, cleared by an accepted start and held between runs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_cnt_q <= '0;
        end else if (start_ok) begin
            sat_cnt_q <= '0;
        end else if (state_q == StExe) begin
            sat_cnt_q <= sat_sum[8] ? 8'hFF : sat_sum[7:0];
        end
    end

    assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_softmax_sub_ctrl.sv
// Self-checking bench for softmax_sub_ctrl: table-driven runs plus hand-written
// sequences for start-while-busy, reset mid-run and (with SUB_SAT_CNT_EN) sat_cnt.
module tb_softmax_sub_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  num_locs;
    logic [3:0]  rd_base;
    logic [8:0]  wr_base;
    logic [15:0] max_in;
    logic        busy, done, rd_en, wr_en, wr_ready;
    logic [3:0]  rd_addr;
    logic [63:0] rd_data;
    logic [15:0] sub_a0, sub_a1, sub_a2, sub_a3, sub_b;
    logic [15:0] sub_res0, sub_res1, sub_res2, sub_res3;
    logic [8:0]  wr_addr;
    logic [63:0] wr_data;
`ifdef SUB_SAT_CNT_EN
    logic [7:0]  sat_cnt;
`endif

    logic [63:0] in_mem [16];
    logic [63:0] out_mem [512];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    softmax_sub_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .num_locs(num_locs), .rd_base(rd_base),
        .wr_base(wr_base), .max_in(max_in), .busy(busy), .done(done), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .sub_a0(sub_a0), .sub_a1(sub_a1),
        .sub_a2(sub_a2), .sub_a3(sub_a3), .sub_b(sub_b), .sub_res0(sub_res0),
        .sub_res1(sub_res1), .sub_res2(sub_res2), .sub_res3(sub_res3), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
`ifdef SUB_SAT_CNT_EN
        , .sat_cnt(sat_cnt)
`endif
    );

    // Datapath model: lane-wise modular subtract
    assign sub_res0 = sub_a0 - sub_b;
    assign sub_res1 = sub_a1 - sub_b;
    assign sub_res2 = sub_a2 - sub_b;
    assign sub_res3 = sub_a3 - sub_b;

    // Input buffer with 1-cycle read, output RAM capturing accepted writes
    always @(posedge clk) begin
        if (rd_en) rd_data <= in_mem[rd_addr];
        if (wr_en && wr_ready) out_mem[wr_addr] <= wr_data;
    end

    typedef struct {
        int          n;
        logic [3:0]  rb;
        logic [8:0]  wb;
        logic [15:0] mx;
        int          stalls;
        int          exp_done;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_word(input int loc, input logic [15:0] m);
        logic [63:0] w;
        logic [63:0] src;
        src = in_mem[loc & 15];
        for (int k = 0; k < 4; k++) w[k*16 +: 16] = src[k*16 +: 16] - m;
        return w;
    endfunction

    // One run: drives start, tracks reads/writes against the model, checks latency
    task automatic run_vec(input vec_t v, input bit poke_start, input bit abort_wr);
        int cyc, acc, rds, stall_left;
        bit seen;
        for (int i = 0; i < 512; i++) out_mem[i] = 64'hDEAD_BEEF_DEAD_BEEF;
        stall_left = v.stalls;
        acc = 0; rds = 0; seen = 0;
        @(negedge clk);
        num_locs = 5'(v.n); rd_base = v.rb; wr_base = v.wb; max_in = v.mx; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc <= 200) begin
            if (done) begin
                seen = 1;
                break;
            end
            chk("sub_b", 64'(sub_b), 64'(v.mx));
            if (rd_en) begin
                chk("rd_addr", 64'(rd_addr), 64'((int'(v.rb) + rds) & 15));
                rds++;
            end
            if (wr_en) begin
                if (stall_left > 0) begin
                    wr_ready = 1'b0;
                    stall_left--;
                end else begin
                    wr_ready = 1'b1;
                end
                chk("wr_addr", 64'(wr_addr), 64'((int'(v.wb) + acc) & 511));
                chk("wr_data", wr_data, exp_word(int'(v.rb) + acc, v.mx));
                if (abort_wr && acc == 1) begin
                    rst = 1'b0;
                    #1;
                    chk("abort_wr_en", 64'(wr_en), 64'd0);
                    chk("abort_busy", 64'(busy), 64'd0);
                    chk("abort_done", 64'(done), 64'd0);
                    #1;
                    rst = 1'b1;
                    wr_ready = 1'b1;
                    return;
                end
                if (wr_ready) acc++;
            end else begin
                wr_ready = 1'b1;
            end
            if (poke_start && busy && !rd_en && !wr_en) begin
                start = 1'b1; num_locs = 5'd5; max_in = 16'h7777; rd_base = 4'd9;
                wr_base = 9'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", 64'(seen), 64'd1);
        chk("done_cycle", 64'(cyc), 64'(v.exp_done));
        chk("rd_count", 64'(rds), 64'(v.n));
        chk("wr_count", 64'(acc), 64'(v.n));
        for (int i = 0; i < v.n; i++)
            chk("out_mem", out_mem[(int'(v.wb) + i) & 511], exp_word(int'(v.rb) + i, v.mx));
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic chk_basic_words();
        chk("basic_w100", out_mem[9'h100], 64'h0003_0002_0001_0000);
        chk("basic_w101", out_mem[9'h101], 64'h0010_0020_0030_0040);
    endtask

    initial begin
        vecs[0] = '{n: 2,  rb: 4'd3,  wb: 9'h100, mx: 16'h0010, stalls: 0, exp_done: 7};
        vecs[1] = '{n: 2,  rb: 4'd3,  wb: 9'h100, mx: 16'h0010, stalls: 3, exp_done: 10};
        vecs[2] = '{n: 0,  rb: 4'd5,  wb: 9'h010, mx: 16'h0001, stalls: 0, exp_done: 1};
        vecs[3] = '{n: 16, rb: 4'd15, wb: 9'h1F8, mx: 16'h0101, stalls: 0, exp_done: 49};
        vecs[4] = '{n: 3,  rb: 4'd14, wb: 9'h050, mx: 16'hFFFF, stalls: 2, exp_done: 12};

        for (int i = 0; i < 16; i++)
            for (int k = 0; k < 4; k++) in_mem[i][k*16 +: 16] = 16'(i * 257 + k * 4099);
        in_mem[3] = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
        in_mem[4] = {16'h0020, 16'h0030, 16'h0040, 16'h0050};

        rst = 1'b0; start = 1'b0; num_locs = '0; rd_base = '0; wr_base = '0;
        max_in = 16'h1234; wr_ready = 1'b1; rd_data = '0;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_addrs", {rd_addr, wr_addr}, 64'd0);
        chk("rst_wr_data", wr_data, 64'd0);
        chk("rst_sub", {sub_a0, sub_a1, sub_a2, sub_a3}, 64'd0);
        chk("rst_sub_b", 64'(sub_b), 64'd0);
`ifdef SUB_SAT_CNT_EN
        chk("rst_sat_cnt", 64'(sat_cnt), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], 1'b0, 1'b0);
            if (i < 2) chk_basic_words();
        end

        // Start pulses during EXE must be ignored
        run_vec(vecs[0], 1'b1, 1'b0);
        chk_basic_words();

        // Reset during the second WR, then a normal run
        run_vec(vecs[0], 1'b0, 1'b1);
        @(negedge clk);
        chk("post_abort_busy", 64'(busy), 64'd0);
        chk("post_abort_done", 64'(done), 64'd0);
        run_vec(vecs[0], 1'b0, 1'b0);
        chk_basic_words();

`ifdef SUB_SAT_CNT_EN
        begin
            vec_t sv;
            bit seen;
            in_mem[0] = {16'h8010, 16'h8010, 16'h0011, 16'h8010};
            sv = '{n: 1, rb: 4'd0, wb: 9'h020, mx: 16'h0010, stalls: 0, exp_done: 4};
            run_vec(sv, 1'b0, 1'b0);
            chk("sat_cnt_after_done", 64'(sat_cnt), 64'd3);
            @(negedge clk);
            chk("sat_cnt_hold", 64'(sat_cnt), 64'd3);
            num_locs = 5'd1; max_in = 16'h0000; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("sat_cnt_clear", 64'(sat_cnt), 64'd0);
            seen = 0;
            for (int c = 0; c < 20 && !seen; c++) begin
                if (done) seen = 1;
                else @(negedge clk);
            end
            chk("sat_run2_done", 64'(seen), 64'd1);
            chk("sat_cnt_run2", 64'(sat_cnt), 64'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
